transmit_beamformer: RTL and testbench

- Drives the ultrasonic transmitter array with delayed 40 kHz square-wave bursts so the emitted wavefront steers toward the angle given by sin_theta/sign_bit.
- Repeats one burst every PERIOD_DURATION cycles.
- Uses the same steering convention as the receive path, so transmit and receive beams point the same way for the same angle inputs.
- Sits between the angle-sweep controller and the transducer driver pins.

---
 rtl/transmit_beamformer_if.sv | 24 ++
 rtl/transmit_beamformer.sv | 215 +++++++++++++++++++++
 tb/tb_transmit_beamformer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/transmit_beamformer_if.sv
// Control/drive bundle between the angle-sweep controller and the transmit
// beamformer. The controller is the master (angle + enable), the beamformer
// is the slave (drives the transducer pins).
interface transmit_beamformer_if #(
  parameter int SIN_WIDTH        = 17,
  parameter int NUM_TRANSMITTERS = 4
);
  logic                        enable_in;
  logic [SIN_WIDTH-1:0]        sin_theta;
  logic                        sign_bit;
  logic [NUM_TRANSMITTERS-1:0] tx_out;
  logic                        burst_active_out;
  logic                        period_start_out;

  modport master (
    output enable_in, sin_theta, sign_bit,
    input  tx_out, burst_active_out, period_start_out
  );

  modport slave (
    input  enable_in, sin_theta, sign_bit,
    output tx_out, burst_active_out, period_start_out
  );
endinterface

// File: rtl/transmit_beamformer.sv
// Transmit beamformer: once per ping period, latches the steering angle,
// computes one element delay per cycle on a shared multiplier, then drives
// each element with a delayed 40 kHz square-wave burst.

// One array element: burst window tracking and square-wave phase.
// Everything is evaluated against the *next* period count so the registered
// outputs line up with the counter value they belong to.
module transmit_beamformer_lane #(
  parameter int CNT_W            = 24,
  parameter int DELAY_WIDTH      = 24,
  parameter int NUM_TRANSMITTERS = 4,
  parameter int BURST_DURATION   = 524288,
  parameter int HALF_CYCLE       = 1250
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   i_live,
  input  logic [CNT_W-1:0]       i_t_next,
  input  logic [DELAY_WIDTH-1:0] i_delay,
  output logic                   o_act_next,
  output logic                   o_tx
);
  localparam int EXT_W = ((CNT_W > DELAY_WIDTH) ? CNT_W : DELAY_WIDTH) + 2;
  localparam int PH_W  = (HALF_CYCLE > 1) ? $clog2(HALF_CYCLE) : 1;

  logic [EXT_W-1:0] w_t, w_start, w_end;
  logic [PH_W-1:0]  r_ph;
  logic             r_act;
  logic             r_tx;

  assign w_t        = EXT_W'(i_t_next);
  assign w_start    = EXT_W'(NUM_TRANSMITTERS) + EXT_W'(i_delay);
  assign w_end      = w_start + EXT_W'(BURST_DURATION);
  assign o_act_next = i_live && (w_t >= w_start) && (w_t < w_end);
  assign o_tx       = r_tx;

  // Window open: start high with phase 0, toggle every HALF_CYCLE; closed: force low.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_act <= 1'b0;
      r_tx  <= 1'b0;
      r_ph  <= '0;
    end else if (!o_act_next) begin
      r_act <= 1'b0;
      r_tx  <= 1'b0;
      r_ph  <= '0;
    end else if (!r_act) begin
      r_act <= 1'b1;
      r_tx  <= 1'b1;
      r_ph  <= '0;
    end else if (r_ph == PH_W'(HALF_CYCLE - 1)) begin
      r_ph <= '0;
      r_tx <= ~r_tx;
    end else begin
      r_ph <= r_ph + PH_W'(1);
    end
  end
endmodule

module transmit_beamformer #(
  parameter int PERIOD_DURATION  = 16777216,
  parameter int BURST_DURATION   = 524288,
  parameter int NUM_TRANSMITTERS = 4,
  parameter int ELEMENT_SPACING  = 9,
  parameter int SPEED_OF_SOUND   = 343000,
  parameter int TARGET_FREQ      = 40000,
  parameter int CLK_FREQ         = 100000000,
  parameter int SIN_WIDTH        = 17,
  parameter int DELAY_WIDTH      = 24
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  transmit_beamformer_if.slave  bus
);
  localparam int     HALF_CYCLE = CLK_FREQ / (2 * TARGET_FREQ);
  localparam longint DPE        = longint'(ELEMENT_SPACING) * longint'(CLK_FREQ)
                                  / longint'(SPEED_OF_SOUND);
  localparam int     MAX_DELAY  = PERIOD_DURATION - BURST_DURATION - NUM_TRANSMITTERS;
  localparam int     CNT_W      = $clog2(PERIOD_DURATION);
  localparam int     IDX_W      = (NUM_TRANSMITTERS > 1) ? $clog2(NUM_TRANSMITTERS) : 1;
  localparam logic [SIN_WIDTH-1:0] SIN_ONE = SIN_WIDTH'(1) << (SIN_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_RUN, S_DRAIN} state_t;

  state_t                                   r_state;
  logic [CNT_W-1:0]                         r_t;
  logic [SIN_WIDTH-1:0]                     r_sin;
  logic                                     r_sign;
  logic [NUM_TRANSMITTERS-1:0][DELAY_WIDTH-1:0] r_delay;
  logic                                     r_pstart;
  logic                                     r_burst;

  logic                                     w_wrap;
  logic                                     w_live_next;
  logic [CNT_W-1:0]                         w_t_next;
  logic [SIN_WIDTH-1:0]                     w_sin_sat;
  logic [IDX_W-1:0]                         w_idx;
  logic [IDX_W-1:0]                         w_k;
  logic [63:0]                              w_prod;
  logic [63:0]                              w_quot;
  logic [DELAY_WIDTH-1:0]                   w_delay_calc;
  logic [NUM_TRANSMITTERS-1:0][DELAY_WIDTH-1:0] w_dly_use;
  logic [NUM_TRANSMITTERS-1:0]              w_act_next;
  logic [NUM_TRANSMITTERS-1:0]              w_tx;

  assign w_wrap    = (r_t == CNT_W'(PERIOD_DURATION - 1));
  assign w_sin_sat = (bus.sin_theta > SIN_ONE) ? SIN_ONE : bus.sin_theta;

  // During COMPUTE the counter doubles as the element index.
  assign w_idx  = r_t[IDX_W-1:0];
  assign w_k    = r_sign ? (IDX_W'(NUM_TRANSMITTERS - 1) - w_idx) : w_idx;
  // DPE*k is a constant times a tiny index; the real multiplier is the one by sin.
  assign w_prod = (64'(DPE) * 64'(w_k)) * 64'(r_sin);
  assign w_quot = w_prod >> (SIN_WIDTH - 1);
  assign w_delay_calc = (w_quot > 64'(MAX_DELAY)) ? DELAY_WIDTH'(MAX_DELAY)
                                                  : w_quot[DELAY_WIDTH-1:0];

  // Next counter value and whether the next cycle belongs to a live period.
  always_comb begin
    w_live_next = 1'b0;
    w_t_next    = '0;
    case (r_state)
      S_IDLE:    w_live_next = bus.enable_in;
      S_COMPUTE: begin
        w_live_next = 1'b1;
        w_t_next    = r_t + CNT_W'(1);
      end
      default: begin
        if (w_wrap) begin
          w_live_next = bus.enable_in;
        end else begin
          w_live_next = 1'b1;
          w_t_next    = r_t + CNT_W'(1);
        end
      end
    endcase
  end

  genvar g;
  generate
    for (g = 0; g < NUM_TRANSMITTERS; g++) begin : g_lane
      // The last element's delay is still being written when its window may
      // open (zero delay, left steer), so bypass the freshly computed value.
      assign w_dly_use[g] = (r_state == S_COMPUTE && w_idx == IDX_W'(g)) ? w_delay_calc
                                                                          : r_delay[g];
      transmit_beamformer_lane #(
        .CNT_W            (CNT_W),
        .DELAY_WIDTH      (DELAY_WIDTH),
        .NUM_TRANSMITTERS (NUM_TRANSMITTERS),
        .BURST_DURATION   (BURST_DURATION),
        .HALF_CYCLE       (HALF_CYCLE)
      ) u_lane (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_live     (w_live_next),
        .i_t_next   (w_t_next),
        .i_delay    (w_dly_use[g]),
        .o_act_next (w_act_next[g]),
        .o_tx       (w_tx[g])
      );
    end
  endgenerate

  // Period sequencer: angle latch, delay computation, run/drain, period pulse.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state  <= S_IDLE;
      r_t      <= '0;
      r_sin    <= '0;
      r_sign   <= 1'b0;
      r_delay  <= '0;
      r_pstart <= 1'b0;
      r_burst  <= 1'b0;
    end else begin
      r_pstart <= 1'b0;
      r_burst  <= |w_act_next;
      case (r_state)
        S_IDLE: begin
          r_t <= '0;
          if (bus.enable_in) begin
            r_state  <= S_COMPUTE;
            r_pstart <= 1'b1;
            r_sin    <= w_sin_sat;
            r_sign   <= bus.sign_bit;
          end
        end
        S_COMPUTE: begin
          r_delay[w_idx] <= w_delay_calc;
          r_t            <= w_t_next;
          if (w_idx == IDX_W'(NUM_TRANSMITTERS - 1)) r_state <= S_RUN;
        end
        default: begin
          if (w_wrap) begin
            r_t <= '0;
            if (bus.enable_in) begin
              r_state  <= S_COMPUTE;
              r_pstart <= 1'b1;
              r_sin    <= w_sin_sat;
              r_sign   <= bus.sign_bit;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_t     <= w_t_next;
            r_state <= bus.enable_in ? S_RUN : S_DRAIN;
          end
        end
      endcase
    end
  end

  assign bus.tx_out           = w_tx;
  assign bus.burst_active_out = r_burst;
  assign bus.period_start_out = r_pstart;
endmodule

// File: tb/tb_transmit_beamformer.sv
// Bench for transmit_beamformer: randomized angle noise against a period-level
// reference model, plus fixed-angle scenarios with known rise times.
module tb_transmit_beamformer;
  localparam int P    = 20000;
  localparam int B    = 5000;
  localparam int N    = 4;
  localparam int SW   = 17;
  localparam int H    = 100000000 / (2 * 40000);
  localparam int DPE  = (9 * 100000000) / 343000;
  localparam int MAXD = P - B - N;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  transmit_beamformer_if #(.SIN_WIDTH(SW), .NUM_TRANSMITTERS(N)) bus();

  transmit_beamformer #(
    .PERIOD_DURATION  (P),
    .BURST_DURATION   (B),
    .NUM_TRANSMITTERS (N)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: period-level view (live flag, count, latched delays).
  bit m_live = 1'b0;
  int m_t    = 0;
  int m_d[N];
  int rise[N];
  int bfirst = -1;
  int blast  = -1;
  int npst   = 0;

  function automatic void latch(input int s, input bit sg);
    int ss;
    longint v;
    ss = (s > 65536) ? 65536 : s;
    for (int i = 0; i < N; i++) begin
      v = longint'(DPE) * longint'(sg ? (N - 1 - i) : i) * longint'(ss) / 65536;
      if (v > MAXD) v = MAXD;
      m_d[i] = int'(v);
    end
  endfunction

  function automatic bit in_win(input int i);
    return m_live && (m_t >= N + m_d[i]) && (m_t < N + m_d[i] + B);
  endfunction

  function automatic logic [N-1:0] exp_tx();
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (in_win(i) && (((m_t - N - m_d[i]) / H) % 2 == 0)) r[i] = 1'b1;
    return r;
  endfunction

  function automatic bit exp_burst();
    bit b;
    b = 1'b0;
    for (int i = 0; i < N; i++) b |= in_win(i);
    return b;
  endfunction

  task automatic model_edge();
    if (!rst_in) begin
      m_live = 1'b0;
      m_t    = 0;
    end else if (!m_live) begin
      if (bus.enable_in) begin
        m_live = 1'b1;
        m_t    = 0;
        latch(int'(bus.sin_theta), bus.sign_bit);
      end
    end else if (m_t == P - 1) begin
      m_t = 0;
      if (bus.enable_in) latch(int'(bus.sin_theta), bus.sign_bit);
      else m_live = 1'b0;
    end else begin
      m_t++;
    end
  endtask

  task automatic observe();
    chk("tx", bus.tx_out, exp_tx());
    chk("burst", bus.burst_active_out, exp_burst());
    chk("pstart", bus.period_start_out, m_live && m_t == 0);
    if (m_live && m_t == 0) begin
      for (int i = 0; i < N; i++) rise[i] = -1;
      bfirst = -1;
      blast  = -1;
    end
    for (int i = 0; i < N; i++)
      if (bus.tx_out[i] === 1'b1 && rise[i] < 0) rise[i] = m_t;
    if (bus.burst_active_out === 1'b1) begin
      if (bfirst < 0) bfirst = m_t;
      blast = m_t;
    end
    if (bus.period_start_out === 1'b1) npst++;
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    observe();
  endtask

  // Advance until the model reaches count tt in a live period; optional angle noise.
  task automatic run_to(input int tt, input bit noise);
    for (int c = 0; c < P + 10; c++) begin
      if (m_live && m_t == tt) return;
      if (noise && m_live) begin
        bus.sin_theta = SW'($urandom_range(0, 131071));
        bus.sign_bit  = 1'($urandom);
      end
      tick();
    end
    n_chk++;
    n_bad++;
    $display("FAIL run_to timeout waiting for t=%0d", tt);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    bus.enable_in = 1'b0;
    tick();
    tick();
    rst_in = 1'b1;
  endtask

  task automatic chk_rise(input string tag, input int r0, input int r1, input int r2, input int r3);
    chk({tag, "_rise0"}, 64'(rise[0]), 64'(r0));
    chk({tag, "_rise1"}, 64'(rise[1]), 64'(r1));
    chk({tag, "_rise2"}, 64'(rise[2]), 64'(r2));
    chk({tag, "_rise3"}, 64'(rise[3]), 64'(r3));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_d[i]  = 0;
      rise[i] = -1;
    end
    bus.enable_in = 1'b0;
    bus.sin_theta = '0;
    bus.sign_bit  = 1'b0;

    // Reset and idle: all outputs low.
    repeat (3) tick();
    rst_in = 1'b1;
    repeat (3) tick();

    // Broadside period with angle noise, then steer right full scale latched at wrap.
    bus.enable_in = 1'b1;
    tick();
    run_to(P - 10, 1'b1);
    bus.sin_theta = SW'(65536);
    bus.sign_bit  = 1'b0;
    run_to(P - 1, 1'b0);
    chk_rise("broad", 4, 4, 4, 4);
    chk("broad_bfirst", 64'(bfirst), 64'(4));
    chk("broad_blast", 64'(blast), 64'(5003));
    tick();
    chk("wrap_npst", 64'(npst), 64'(2));

    // Disable at t=3000; the period drains and no further pulse appears.
    run_to(2999, 1'b1);
    bus.enable_in = 1'b0;
    run_to(13000, 1'b1);
    chk_rise("right", 4, 2627, 5250, 7873);
    chk("right_bfirst", 64'(bfirst), 64'(4));
    chk("right_blast", 64'(blast), 64'(12872));
    for (int c = 0; c < P && m_live; c++) tick();
    repeat (20) tick();
    chk("drain_npst", 64'(npst), 64'(2));

    // Steer left at half scale.
    do_reset();
    bus.sin_theta = SW'(32768);
    bus.sign_bit  = 1'b1;
    bus.enable_in = 1'b1;
    tick();
    run_to(9000, 1'b0);
    chk_rise("left", 3938, 2627, 1315, 4);
    chk("left_blast", 64'(blast), 64'(8937));

    // Saturated sin_theta behaves as full scale; noise after latch is ignored.
    do_reset();
    bus.sin_theta = SW'(131071);
    bus.sign_bit  = 1'b0;
    bus.enable_in = 1'b1;
    tick();
    run_to(8000, 1'b1);
    chk_rise("sat", 4, 2627, 5250, 7873);

    // Asynchronous reset mid-burst, then a fresh period with a random angle.
    do_reset();
    bus.sin_theta = SW'($urandom_range(0, 131071));
    bus.sign_bit  = 1'($urandom);
    bus.enable_in = 1'b1;
    tick();
    run_to(2000, 1'b1);
    chk("areset_pre_burst", bus.burst_active_out, 1);
    #2 rst_in = 1'b0;
    #1;
    chk("areset_tx", bus.tx_out, 0);
    chk("areset_burst", bus.burst_active_out, 0);
    tick();
    rst_in = 1'b1;
    bus.sin_theta = SW'($urandom_range(0, 131071));
    bus.sign_bit  = 1'($urandom);
    npst = 0;
    tick();
    chk("areset_restart_pulse", 64'(npst), 64'(1));
    run_to(13000, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
